jtag_1149_d10_mstr_rx_flow_ctrl_tracker: RTL and testbench

JTAG_1149_D10_MSTR_RX_FLOW_CTRL_TRACKER -- requirements
Module: jtag_1149_d10_mstr_rx_flow_ctrl_tracker

---
 rtl/jtag_1149_d10_mstr_rx_flow_ctrl_tracker_pkg.sv | 15 +
 rtl/jtag_1149_d10_mstr_rx_fc_pause_timer.sv | 40 ++++
 rtl/jtag_1149_d10_mstr_rx_flow_ctrl_tracker.sv | 147 ++++++++++++++
 tb/tb_jtag_1149_d10_mstr_rx_flow_ctrl_tracker.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_1149_d10_mstr_rx_flow_ctrl_tracker_pkg.sv
// Shared definitions for the JTAG 8b/10b rx flow-control tracker:
// flow-control K-characters and the sequence FSM state encoding.
package jtag_1149_d10_mstr_rx_flow_ctrl_tracker_pkg;

    localparam logic [7:0] IDLE_CHAR = 8'hBC;
    localparam logic [7:0] XOFF_CHAR = 8'h7C;
    localparam logic [7:0] XON_CHAR  = 8'h1C;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        RUN_XOFF = 2'd1,
        RUN_XON  = 2'd2
    } fc_state_e;

endpackage

// File: rtl/jtag_1149_d10_mstr_rx_fc_pause_timer.sv
// Pause timeout counter; exists only when JTAG_D10_FC_TIMEOUT_EN is defined.
// Counts cycles since the pause started and flags the edge at which it reaches tmo_val_i.
`ifdef JTAG_D10_FC_TIMEOUT_EN
module jtag_1149_d10_mstr_rx_fc_pause_timer #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             paused_i,
    input  logic             restart_i,
    input  logic [TMO_W-1:0] tmo_val_i,
    output logic             expire_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] cnt_inc;

    assign cnt_inc  = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    // A fresh XOFF on the expiry edge keeps the pause, so restart masks expiry.
    assign expire_o = paused_i && !restart_i && (tmo_val_i != '0) && (cnt_inc == tmo_val_i);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || !paused_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/jtag_1149_d10_mstr_rx_flow_ctrl_tracker.sv
// Tracks XOFF/XON K-character runs on the rx path and drives the tx pause level.
// Optional pause timeout is built only when JTAG_D10_FC_TIMEOUT_EN is defined.
module jtag_1149_d10_mstr_rx_flow_ctrl_tracker
    import jtag_1149_d10_mstr_rx_flow_ctrl_tracker_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SEQ_LEN    = 4,
    parameter int TMO_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] decoded_data,
    input  logic                  decoder_k_out,
    input  logic [TMO_W-1:0]      xoff_tmo_val,
    output logic                  xoff_detected,
    output logic                  xon_detected,
    output logic                  tx_paused,
    output logic                  seq_error,
    output logic                  pause_timeout
);

    localparam logic [3:0]            SEQ_LEN_C = 4'(SEQ_LEN);
    localparam logic [DATA_WIDTH-1:0] IDLE_C    = DATA_WIDTH'(IDLE_CHAR);
    localparam logic [DATA_WIDTH-1:0] XOFF_C    = DATA_WIDTH'(XOFF_CHAR);
    localparam logic [DATA_WIDTH-1:0] XON_C     = DATA_WIDTH'(XON_CHAR);

    fc_state_e  state_q, state_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic       xoff_d, xon_d, err_d, paused_d, tmo_d;
    logic       xoff_q, xon_q, err_q, paused_q, tmo_q;
    logic       is_idle, is_xoff, is_xon, same_run, expire;

    assign is_idle  = decoder_k_out && (decoded_data == IDLE_C);
    assign is_xoff  = decoder_k_out && (decoded_data == XOFF_C);
    assign is_xon   = decoder_k_out && (decoded_data == XON_C);
    assign same_run = ((state_q == RUN_XOFF) && is_xoff) || ((state_q == RUN_XON) && is_xon);

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        xoff_d    = 1'b0;
        xon_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            HUNT: begin
                run_cnt_d = 4'd0;
                if (is_xoff) begin
                    state_d   = RUN_XOFF;
                    run_cnt_d = 4'd1;
                end else if (is_xon) begin
                    state_d   = RUN_XON;
                    run_cnt_d = 4'd1;
                end
            end
            RUN_XOFF, RUN_XON: begin
                if (same_run) begin
                    if (run_cnt_q < SEQ_LEN_C) begin
                        run_cnt_d = run_cnt_q + 4'd1;
                    end
                end else if (is_idle) begin
                    state_d   = HUNT;
                    run_cnt_d = 4'd0;
                    if (run_cnt_q >= SEQ_LEN_C) begin
                        xoff_d = (state_q == RUN_XOFF);
                        xon_d  = (state_q == RUN_XON);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (is_xoff || is_xon) begin
                    // Opposite flow char aborts this run and starts the other one.
                    run_cnt_d = 4'd1;
                    err_d     = 1'b1;
                    if (is_xoff) begin
                        state_d = RUN_XOFF;
                    end else begin
                        state_d = RUN_XON;
                    end
                end else begin
                    state_d   = HUNT;
                    run_cnt_d = 4'd0;
                    err_d     = 1'b1;
                end
            end
            default: begin
                state_d   = HUNT;
                run_cnt_d = 4'd0;
            end
        endcase
    end

`ifdef JTAG_D10_FC_TIMEOUT_EN
    jtag_1149_d10_mstr_rx_fc_pause_timer #(
        .TMO_W (TMO_W)
    ) u_pause_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .paused_i  (paused_q),
        .restart_i (xoff_d),
        .tmo_val_i (xoff_tmo_val),
        .expire_o  (expire)
    );
`else
    logic unused_tmo_val;
    assign unused_tmo_val = ^xoff_tmo_val;
    assign expire         = 1'b0;
`endif

    always_comb begin
        paused_d = paused_q;
        tmo_d    = 1'b0;
        if (xoff_d) begin
            paused_d = 1'b1;
        end else if (xon_d) begin
            paused_d = 1'b0;
        end else if (expire) begin
            paused_d = 1'b0;
            tmo_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            run_cnt_q <= 4'd0;
            xoff_q    <= 1'b0;
            xon_q     <= 1'b0;
            err_q     <= 1'b0;
            paused_q  <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            xoff_q    <= xoff_d;
            xon_q     <= xon_d;
            err_q     <= err_d;
            paused_q  <= paused_d;
            tmo_q     <= tmo_d;
        end
    end

    assign xoff_detected = xoff_q;
    assign xon_detected  = xon_q;
    assign seq_error     = err_q;
    assign tx_paused     = paused_q;
    assign pause_timeout = tmo_q;

endmodule

// File: tb/tb_jtag_1149_d10_mstr_rx_flow_ctrl_tracker.sv
// Self-checking bench for the rx flow-control tracker: directed K-char runs,
// a run-length reference model checked every cycle, and literal spot checks.
`timescale 1ns/1ps
module tb_jtag_1149_d10_mstr_rx_flow_ctrl_tracker;

    localparam int SL = 4;
`ifdef JTAG_D10_FC_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  decoded_data = 8'h00;
    logic        decoder_k_out = 1'b0;
    logic [15:0] xoff_tmo_val = 16'd0;
    logic        xoff_detected, xon_detected, tx_paused, seq_error, pause_timeout;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    jtag_1149_d10_mstr_rx_flow_ctrl_tracker #(
        .DATA_WIDTH (8),
        .SEQ_LEN    (SL),
        .TMO_W      (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .decoded_data  (decoded_data),
        .decoder_k_out (decoder_k_out),
        .xoff_tmo_val  (xoff_tmo_val),
        .xoff_detected (xoff_detected),
        .xon_detected  (xon_detected),
        .tx_paused     (tx_paused),
        .seq_error     (seq_error),
        .pause_timeout (pause_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: current run is (char, length); events come from run length at BC.
    int     m_run_char = 0;
    int     m_run_len = 0;
    bit     m_paused = 1'b0;
    longint cyc = 0;
    longint pause_start = 0;
    bit     e_xoff = 1'b0, e_xon = 1'b0, e_err = 1'b0, e_paused = 1'b0, e_to = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int ev;
        if (!rst_n) begin
            m_run_char = 0;
            m_run_len  = 0;
            m_paused   = 1'b0;
            cyc        = 0;
            e_xoff = 1'b0; e_xon = 1'b0; e_err = 1'b0; e_paused = 1'b0; e_to = 1'b0;
        end else begin
            ev = 0;
            if (m_run_len == 0) begin
                if (decoder_k_out && (decoded_data == 8'h7C || decoded_data == 8'h1C)) begin
                    m_run_char = decoded_data;
                    m_run_len  = 1;
                end
            end else if (decoder_k_out && decoded_data == m_run_char) begin
                m_run_len++;
            end else if (decoder_k_out && decoded_data == 8'hBC) begin
                if (m_run_len >= SL) ev = (m_run_char == 8'h7C) ? 1 : 2;
                else ev = 3;
                m_run_len = 0;
            end else if (decoder_k_out && (decoded_data == 8'h7C || decoded_data == 8'h1C)) begin
                ev = 3;
                m_run_char = decoded_data;
                m_run_len  = 1;
            end else begin
                ev = 3;
                m_run_len = 0;
            end
            cyc++;
            e_to = 1'b0;
            if (ev == 1) begin
                m_paused = 1'b1;
                pause_start = cyc;
            end else if (ev == 2) begin
                m_paused = 1'b0;
            end else if (TMO_EN && m_paused && xoff_tmo_val != 0 &&
                         (cyc - pause_start) == longint'(xoff_tmo_val)) begin
                m_paused = 1'b0;
                e_to = 1'b1;
            end
            e_xoff   = (ev == 1);
            e_xon    = (ev == 2);
            e_err    = (ev == 3);
            e_paused = m_paused;
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("m_xoff_detected", xoff_detected, e_xoff);
            chk("m_xon_detected", xon_detected, e_xon);
            chk("m_seq_error", seq_error, e_err);
            chk("m_tx_paused", tx_paused, e_paused);
            chk("m_pause_timeout", pause_timeout, e_to);
            chk("pulse_onehot", 32'(((32'(xoff_detected) + 32'(xon_detected) + 32'(seq_error)) <= 1)), 1);
        end
    end

    task automatic send(input bit k, input logic [7:0] d);
        decoder_k_out = k;
        decoded_data  = d;
        @(negedge clk);
    endtask

    task automatic send_n(input bit k, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) send(k, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 8'h00);
    endtask

    task automatic async_reset(input string tag);
        decoder_k_out = 1'b0;
        decoded_data  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_xoff"}, xoff_detected, 0);
        chk({tag, "_xon"}, xon_detected, 0);
        chk({tag, "_err"}, seq_error, 0);
        chk({tag, "_paused"}, tx_paused, 0);
        chk({tag, "_tmo"}, pause_timeout, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        chk("rst_xoff", xoff_detected, 0);
        chk("rst_xon", xon_detected, 0);
        chk("rst_err", seq_error, 0);
        chk("rst_paused", tx_paused, 0);
        chk("rst_tmo", pause_timeout, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        // Basic pause / release
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        chk("xoff_pulse", xoff_detected, 1);
        chk("xoff_paused", tx_paused, 1);
        idle(1);
        chk("xoff_one_cycle", xoff_detected, 0);
        chk("paused_hold", tx_paused, 1);
        send_n(1, 8'h1C, 4); send(1, 8'hBC);
        chk("xon_pulse", xon_detected, 1);
        chk("xon_released", tx_paused, 0);

        // Too-short XOFF run
        send_n(1, 8'h7C, 3); send(1, 8'hBC);
        chk("short_err", seq_error, 1);
        chk("short_no_xoff", xoff_detected, 0);
        chk("short_paused", tx_paused, 0);

        // Short run and repeat XOFF while paused
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        send_n(1, 8'h7C, 3); send(1, 8'hBC);
        chk("short_in_pause_err", seq_error, 1);
        chk("short_in_pause_paused", tx_paused, 1);
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        chk("xoff_again", xoff_detected, 1);
        chk("xoff_again_paused", tx_paused, 1);
        send_n(1, 8'h1C, 6); send(1, 8'hBC);
        chk("long_xon", xon_detected, 1);
        chk("long_xon_paused", tx_paused, 0);

        // XON while not paused
        send_n(1, 8'h1C, 4); send(1, 8'hBC);
        chk("xon_unpaused", xon_detected, 1);
        chk("xon_unpaused_level", tx_paused, 0);

        // XOFF run interrupted by XON run
        send_n(1, 8'h7C, 2); send(1, 8'h1C);
        chk("switch_err", seq_error, 1);
        send_n(1, 8'h1C, 3); send(1, 8'hBC);
        chk("switch_xon", xon_detected, 1);

        // Data character inside a run
        send_n(1, 8'h7C, 2); send(0, 8'h55);
        chk("data_err", seq_error, 1);
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        chk("data_then_xoff", xoff_detected, 1);

        // Foreign K char inside a run; BC in HUNT is silent
        send_n(1, 8'h1C, 4); send(1, 8'hFB);
        chk("foreign_k_err", seq_error, 1);
        chk("foreign_k_paused", tx_paused, 1);
        send(1, 8'hBC);
        chk("hunt_bc_err", seq_error, 0);
        chk("hunt_bc_xon", xon_detected, 0);

        // Long run saturates but still detects; single-char run is short
        send_n(1, 8'h1C, 20); send(1, 8'hBC);
        chk("sat_xon", xon_detected, 1);
        chk("sat_paused", tx_paused, 0);
        send(1, 8'h7C); send(1, 8'hBC);
        chk("len1_err", seq_error, 1);

`ifdef JTAG_D10_FC_TIMEOUT_EN
        xoff_tmo_val = 16'd10;
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        n = 0;
        while (pause_timeout !== 1'b1 && n < 50) begin idle(1); n++; end
        chk("tmo_cycles", n, 10);
        chk("tmo_released", tx_paused, 0);

        // Restart by a fresh XOFF mid-pause
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        idle(3);
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        n = 0;
        while (pause_timeout !== 1'b1 && n < 50) begin idle(1); n++; end
        chk("tmo_restart_cycles", n, 10);

        // XOFF on the exact expiry edge wins
        xoff_tmo_val = 16'd5;
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        chk("collide_xoff", xoff_detected, 1);
        chk("collide_no_tmo", pause_timeout, 0);
        chk("collide_paused", tx_paused, 1);
        n = 0;
        while (pause_timeout !== 1'b1 && n < 50) begin idle(1); n++; end
        chk("collide_tmo_cycles", n, 5);

        xoff_tmo_val = 16'd0;
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        idle(40);
        chk("tmo_disabled_paused", tx_paused, 1);
        send_n(1, 8'h1C, 4); send(1, 8'hBC);
`else
        xoff_tmo_val = 16'd10;
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        idle(30);
        chk("no_tmo_paused", tx_paused, 1);
        chk("no_tmo_pulse", pause_timeout, 0);
        send_n(1, 8'h1C, 4); send(1, 8'hBC);
        chk("no_tmo_xon_release", tx_paused, 0);
`endif

        // Reset in the middle of a run discards progress
        send_n(1, 8'h7C, 2);
        async_reset("rst_run");
        send_n(1, 8'h7C, 2); send(1, 8'hBC);
        chk("post_rst_short", seq_error, 1);
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        chk("post_rst_xoff", xoff_detected, 1);
        chk("post_rst_paused", tx_paused, 1);

        // Reset during a pause
        idle(3);
        async_reset("rst_pause");
        send_n(1, 8'h7C, 4); send(1, 8'hBC);
        chk("post_rst2_xoff", xoff_detected, 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
